// File: rtl/outer_out_adapter_fifo.sv
// Hub-to-outer output adapter: one framed transfer per command, buffered
// through a DEPTH-entry FWFT FIFO, with a per-transfer completion report.
module outer_out_adapter_fifo #(
  parameter int W        = 64,
  parameter int LEN_BITS = 15,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LEN_BITS-1:0] cmd,
  input  logic                cmd_isReady,
  output logic                cmd_canReceive,
  input  logic [W-1:0]        h__out,
  input  logic                h__out_isReady,
  output logic                h__out_canReceive,
  output logic                h__out_isLast_in,
  input  logic                h__out_isLast_out,
  output logic [W-1:0]        o__out,
  output logic                o__out_isReady,
  input  logic                o__out_canReceive,
  output logic                o__out_isLast,
  output logic                stat_isReady,
  output logic [LEN_BITS-1:0] stat_count,
  output logic                stat_early
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN_CNT,
    RUN_AUTO,
    DRAIN
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [W:0]          r_mem [DEPTH];
  logic [AW:0]         r_wptr;
  logic [AW:0]         r_rptr;
  logic [LEN_BITS-1:0] r_rem;
  logic [LEN_BITS-1:0] r_count;
  logic                r_early;

  logic       w_empty;
  logic       w_full;
  logic       w_run;
  logic       w_push;
  logic       w_pop;
  logic       w_cmd_acc;
  logic       w_cnt_last;
  logic       w_last_word;
  logic       w_done;
  logic [W:0] w_head;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_head  = r_mem[r_rptr[AW-1:0]];

  assign w_run      = (r_state == RUN_CNT) || (r_state == RUN_AUTO);
  assign w_push     = w_run && !w_full && !rst && h__out_isReady;
  assign w_pop      = !w_empty && !rst && o__out_canReceive;
  assign w_cmd_acc  = (r_state == IDLE) && !rst && cmd_isReady;
  assign w_cnt_last = (r_state == RUN_CNT) && (r_rem == LEN_BITS'(1));
  assign w_done     = (r_state == DRAIN) && w_pop && w_head[W];

  // The final word is either the counted one or the one the hub flags.
  assign w_last_word = w_cnt_last || h__out_isLast_out;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_cmd_acc)
          w_next = (cmd != '0) ? RUN_CNT : RUN_AUTO;
      end
      RUN_CNT, RUN_AUTO: begin
        if (w_push && w_last_word)
          w_next = DRAIN;
      end
      DRAIN: begin
        if (w_done)
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_rem   <= '0;
      r_count <= '0;
      r_early <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_push)
        r_wptr <= r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
      if (w_cmd_acc) begin
        r_rem   <= cmd;
        r_count <= '0;
        r_early <= 1'b0;
      end
      if (w_push) begin
        r_count <= r_count + LEN_BITS'(1);
        if (r_state == RUN_CNT)
          r_rem <= r_rem - LEN_BITS'(1);
        if (w_last_word)
          r_early <= (r_state == RUN_CNT) && !w_cnt_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr[AW-1:0]] <= {w_last_word, h__out};
  end

  assign cmd_canReceive    = (r_state == IDLE) && !rst;
  assign h__out_canReceive = w_run && !w_full && !rst;
  assign h__out_isLast_in  = w_cnt_last && !rst;
  assign o__out_isReady    = !w_empty && !rst;
  assign o__out            = o__out_isReady ? w_head[W-1:0] : '0;
  assign o__out_isLast     = o__out_isReady && w_head[W];
  assign stat_isReady      = w_done;
  assign stat_count        = w_done ? r_count : '0;
  assign stat_early        = w_done && r_early;

endmodule

// File: tb/tb_outer_out_adapter_fifo.sv
// Scoreboard bench for outer_out_adapter_fifo: randomized transfers checked
// against a transfer-level model of words, last flags and completion stats.
module tb_outer_out_adapter_fifo;

  localparam int W  = 32;
  localparam int LB = 4;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [LB-1:0] cmd;
  logic          cmd_isReady;
  logic          cmd_canReceive;
  logic [W-1:0]  h__out;
  logic          h__out_isReady;
  logic          h__out_canReceive;
  logic          h__out_isLast_in;
  logic          h__out_isLast_out;
  logic [W-1:0]  o__out;
  logic          o__out_isReady;
  logic          o__out_canReceive;
  logic          o__out_isLast;
  logic          stat_isReady;
  logic [LB-1:0] stat_count;
  logic          stat_early;

  outer_out_adapter_fifo #(.W(W), .LEN_BITS(LB), .DEPTH(D)) dut (
    .clk(clk),
    .rst(rst),
    .cmd(cmd),
    .cmd_isReady(cmd_isReady),
    .cmd_canReceive(cmd_canReceive),
    .h__out(h__out),
    .h__out_isReady(h__out_isReady),
    .h__out_canReceive(h__out_canReceive),
    .h__out_isLast_in(h__out_isLast_in),
    .h__out_isLast_out(h__out_isLast_out),
    .o__out(o__out),
    .o__out_isReady(o__out_isReady),
    .o__out_canReceive(o__out_canReceive),
    .o__out_isLast(o__out_isLast),
    .stat_isReady(stat_isReady),
    .stat_count(stat_count),
    .stat_early(stat_early)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         last;
    logic [W-1:0] data;
  } word_t;

  typedef struct packed {
    logic [LB-1:0] cnt;
    logic          early;
  } stat_t;

  word_t exp_q[$];
  stat_t stat_q[$];
  word_t mw;
  stat_t ms;
  int    n_tests = 0;
  int    n_fail = 0;
  int    sink_mode = 0;
  int    hub_rate = 100;
  int    g_acc = 0;
  logic  stat_seen = 1'b0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timeout, got no progress expected completion", name);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  endtask

  always @(posedge clk) begin
    #1;
    case (sink_mode)
      0:       o__out_canReceive = 1'b1;
      1:       o__out_canReceive = 1'($urandom % 2);
      default: o__out_canReceive = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (stat_seen)
      check("cmd_ready_after_stat", cmd_canReceive, 1);
    stat_seen = 1'b0;
    if (!rst && o__out_isReady && o__out_canReceive) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 1, 0);
      end else begin
        mw = exp_q.pop_front();
        check("out_data", o__out, mw.data);
        check("out_last", o__out_isLast, mw.last);
      end
    end
    if (stat_isReady) begin
      check("cmd_busy_at_stat", cmd_canReceive, 0);
      if (stat_q.size() == 0) begin
        check("unexpected_stat", 1, 0);
      end else begin
        ms = stat_q.pop_front();
        check("stat_count", stat_count, ms.cnt);
        check("stat_early", stat_early, ms.early);
      end
      stat_seen = 1'b1;
    end
  end

  // k = 1-based index of the word the hub flags as last (0 = none).
  task automatic xfer(input int size, input int k, input int base);
    int           n;
    int           cyc;
    logic         early;
    logic [W-1:0] d[$];
    if (size == 0)
      n = k;
    else if (k >= 1 && k < size)
      n = k;
    else
      n = size;
    early = (size != 0) && (k >= 1) && (k < size);
    for (int i = 0; i < n; i++) begin
      d.push_back((base != 0) ? W'(base + i) : W'($urandom));
      exp_q.push_back({(i == n - 1), d[i]});
    end
    stat_q.push_back({LB'(n), early});
    cmd = LB'(size);
    cmd_isReady = 1'b1;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (cmd_canReceive) break;
      cyc++;
      if (cyc > 500) timeout("cmd_accept");
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    cmd_isReady = 1'b0;
    cmd = LB'($urandom);
    g_acc = 0;
    cyc = 0;
    while (g_acc < n) begin
      h__out_isReady = ($urandom % 100) < hub_rate;
      h__out = d[g_acc];
      h__out_isLast_out = h__out_isReady ? (g_acc + 1 == k) : 1'($urandom % 2);
      @(negedge clk);
      if (size != 0)
        check("isLast_in_cnt", h__out_isLast_in, (g_acc == size - 1));
      else
        check("isLast_in_auto", h__out_isLast_in, 0);
      if (h__out_isReady && h__out_canReceive) g_acc++;
      @(posedge clk);
      #1;
      cyc++;
      if (cyc > 2000) timeout("hub_words");
    end
    h__out_isReady = 1'b0;
    h__out_isLast_out = 1'b0;
    cyc = 0;
    while (stat_q.size() != 0) begin
      @(posedge clk);
      cyc++;
      if (cyc > 2000) timeout("stat_pulse");
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    cmd = '0;
    cmd_isReady = 1'b0;
    h__out = '0;
    h__out_isReady = 1'b0;
    h__out_isLast_out = 1'b0;
    o__out_canReceive = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_rdy", cmd_canReceive, 0);
    check("rst_out_vld", o__out_isReady, 0);
    check("rst_hub_rdy", h__out_canReceive, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_cmd_rdy", cmd_canReceive, 1);
    check("idle_out_vld", o__out_isReady, 0);
    check("idle_stat", stat_isReady, 0);
    @(posedge clk);
    #1;

    sink_mode = 0;
    hub_rate = 100;
    xfer(3, 0, 'hA);
    xfer(0, 5, 'h200);
    xfer(8, 3, 'h300);

    sink_mode = 2;
    @(posedge clk);
    #1;
    fork
      xfer(6, 0, 'h100);
      begin
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("depth_words_acc", g_acc, D);
        check("depth_hub_stall", h__out_canReceive, 0);
        check("depth_out_vld", o__out_isReady, 1);
        sink_mode = 0;
      end
    join

    sink_mode = 2;
    @(posedge clk);
    #1;
    cmd = LB'(8);
    cmd_isReady = 1'b1;
    @(negedge clk);
    check("pre_rst_cmd_rdy", cmd_canReceive, 1);
    @(posedge clk);
    #1;
    cmd_isReady = 1'b0;
    h__out_isReady = 1'b1;
    h__out_isLast_out = 1'b0;
    repeat (2) begin
      h__out = W'($urandom);
      @(posedge clk);
      #1;
    end
    h__out_isReady = 1'b0;
    @(negedge clk);
    check("pre_rst_buffered", o__out_isReady, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("in_rst_cmd_rdy", cmd_canReceive, 0);
    check("in_rst_out_vld", o__out_isReady, 0);
    check("in_rst_out_data", o__out, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sink_mode = 0;
    @(negedge clk);
    check("post_rst_out_vld", o__out_isReady, 0);
    check("post_rst_cmd_rdy", cmd_canReceive, 1);
    @(posedge clk);
    #1;
    xfer(1, 0, 'h55);

    xfer(0, 17, 0);

    repeat (25) begin
      sink_mode = int'($urandom % 2);
      hub_rate = 50 + int'($urandom % 51);
      xfer(int'($urandom % 16), int'($urandom_range(1, 20)), 0);
    end

    repeat (5) @(posedge clk);
    check("queues_drained", exp_q.size() + stat_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
